// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned DMEM_DATA_W = 32;

  // Read-size encodings
  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_BYTE = 2'b01;
  localparam logic [1:0] RD_HALF = 2'b10;
  localparam logic [1:0] RD_WORD = 2'b11;

  // Owner tags
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0]   addr;
    logic [DMEM_DATA_W/8-1:0] wr_en;
    logic [1:0]               rd_en;
    logic [DMEM_DATA_W-1:0]   wr_data;
  } dmem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with last-grant pointer.
// DMEM_ARB_LOCK_EN adds lock_i, giving input 1 exclusive grant while the lock is held.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
`ifdef DMEM_ARB_LOCK_EN
  input  logic       lock_i,
`endif
  output logic [1:0] gnt_o
);

  logic last_q, last_d;
  logic held;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q, lock_d;
  // Lock is held only once port 1 has been accepted with lock_i high.
  assign held = lock_i & lock_q;
`else
  assign held = 1'b0;
`endif

  // Grant selection: lock first, then round-robin on a tie.
  always_comb begin
    gnt_o = 2'b00;
    if (!reset) begin
      if (held) begin
        gnt_o = {req_i[1], 1'b0};
      end else if (req_i == 2'b11) begin
        gnt_o = (last_q == PORT_HOST) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Pointer and lock next state; a grant always implies an accept.
  always_comb begin
    last_d = last_q;
    if (gnt_o[0]) begin
      last_d = PORT_CORE;
    end else if (gnt_o[1]) begin
      last_d = PORT_HOST;
    end
`ifdef DMEM_ARB_LOCK_EN
    lock_d = lock_q;
    if (!lock_i) begin
      lock_d = 1'b0;
    end else if (gnt_o[1]) begin
      lock_d = 1'b1;
    end
`endif
  end

  // Arbitration state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= PORT_HOST;
`ifdef DMEM_ARB_LOCK_EN
      lock_q <= 1'b0;
`endif
    end else begin
      last_q <= last_d;
`ifdef DMEM_ARB_LOCK_EN
      lock_q <= lock_d;
`endif
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-ported data memory.
// Stage A drives the memory from registered request copies; stage B returns the response.
// Optional macro DMEM_ARB_LOCK_EN adds p1_lock_i for exclusive host bursts.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                p0_req_i,
  input  logic [ADDR_W-1:0]   p0_addr_i,
  input  logic [DATA_W/8-1:0] p0_wr_en_i,
  input  logic [1:0]          p0_rd_en_i,
  input  logic [DATA_W-1:0]   p0_wr_data_i,
  output logic                p0_gnt_o,
  output logic                p0_resp_o,
  output logic [DATA_W-1:0]   p0_rd_data_o,
  input  logic                p1_req_i,
  input  logic [ADDR_W-1:0]   p1_addr_i,
  input  logic [DATA_W/8-1:0] p1_wr_en_i,
  input  logic [1:0]          p1_rd_en_i,
  input  logic [DATA_W-1:0]   p1_wr_data_i,
  output logic                p1_gnt_o,
  output logic                p1_resp_o,
  output logic [DATA_W-1:0]   p1_rd_data_o,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                p1_lock_i,
`endif
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W/8-1:0] mem_wr_en_o,
  output logic [1:0]          mem_rd_en_o,
  output logic [DATA_W-1:0]   mem_wr_data_o,
  input  logic [DATA_W-1:0]   mem_rd_data_i
);

  // The request struct fixes field widths at the package values.
  dmem_req_t p0_req, p1_req, sel_req;
  logic [1:0] gnt;
  logic       accept;

  logic                a_valid_q, a_valid_d, a_owner_q, a_owner_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W/8-1:0] mem_wr_en_q, mem_wr_en_d;
  logic [1:0]          mem_rd_en_q, mem_rd_en_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic                b_valid_q, b_owner_q;
  logic [DATA_W-1:0]   p0_rd_data_q, p0_rd_data_d, p1_rd_data_q, p1_rd_data_d;
  logic [DATA_W-1:0]   rd_capture;

  assign p0_req = '{addr: p0_addr_i, wr_en: p0_wr_en_i, rd_en: p0_rd_en_i, wr_data: p0_wr_data_i};
  assign p1_req = '{addr: p1_addr_i, wr_en: p1_wr_en_i, rd_en: p1_rd_en_i, wr_data: p1_wr_data_i};

  rr_arbiter2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req_i  ({p1_req_i, p0_req_i}),
`ifdef DMEM_ARB_LOCK_EN
    .lock_i (p1_lock_i),
`endif
    .gnt_o  (gnt)
  );

  assign p0_gnt_o = gnt[0];
  assign p1_gnt_o = gnt[1];
  assign accept   = |gnt;
  assign sel_req  = gnt[1] ? p1_req : p0_req;

  // Stage A next state: load accepted request; writes suppress the read.
  always_comb begin
    a_valid_d     = accept;
    a_owner_d     = gnt[1] ? PORT_HOST : PORT_CORE;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_en_d   = '0;
    mem_rd_en_d   = RD_NONE;
    if (accept) begin
      mem_addr_d    = sel_req.addr;
      mem_wr_data_d = sel_req.wr_data;
      mem_wr_en_d   = sel_req.wr_en;
      mem_rd_en_d   = (|sel_req.wr_en) ? RD_NONE : sel_req.rd_en;
    end
  end

  // Stage B next state: capture read data for the owning port only.
  always_comb begin
    rd_capture   = (mem_rd_en_q != RD_NONE) ? mem_rd_data_i : '0;
    p0_rd_data_d = p0_rd_data_q;
    p1_rd_data_d = p1_rd_data_q;
    if (a_valid_q && (a_owner_q == PORT_CORE)) p0_rd_data_d = rd_capture;
    if (a_valid_q && (a_owner_q == PORT_HOST)) p1_rd_data_d = rd_capture;
  end

  // Pipeline registers; reset drops anything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_valid_q     <= 1'b0;
      a_owner_q     <= PORT_CORE;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= '0;
      mem_rd_en_q   <= RD_NONE;
      mem_wr_data_q <= '0;
      b_valid_q     <= 1'b0;
      b_owner_q     <= PORT_CORE;
      p0_rd_data_q  <= '0;
      p1_rd_data_q  <= '0;
    end else begin
      a_valid_q     <= a_valid_d;
      a_owner_q     <= a_owner_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      b_valid_q     <= a_valid_q;
      b_owner_q     <= a_owner_q;
      p0_rd_data_q  <= p0_rd_data_d;
      p1_rd_data_q  <= p1_rd_data_d;
    end
  end

  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_en_o   = mem_wr_en_q;
  assign mem_rd_en_o   = mem_rd_en_q;
  assign mem_wr_data_o = mem_wr_data_q;
  assign p0_resp_o     = b_valid_q && (b_owner_q == PORT_CORE);
  assign p1_resp_o     = b_valid_q && (b_owner_q == PORT_HOST);
  assign p0_rd_data_o  = p0_rd_data_q;
  assign p1_rd_data_o  = p1_rd_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle vector table plus reset and lock sequences.
// Build with DMEM_ARB_LOCK_EN defined to also exercise the host lock.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        p0_req, p1_req;
  logic [31:0] p0_addr, p1_addr, p0_wr_data, p1_wr_data;
  logic [3:0]  p0_wr_en, p1_wr_en;
  logic [1:0]  p0_rd_en, p1_rd_en;
  logic        p0_gnt, p1_gnt, p0_resp, p1_resp;
  logic [31:0] p0_rd_data, p1_rd_data;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [3:0]  mem_wr_en;
  logic [1:0]  mem_rd_en;
`ifdef DMEM_ARB_LOCK_EN
  logic        p1_lock;
`endif

  int checks = 0;
  int errors = 0;

  dmem_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .p0_req_i      (p0_req),
    .p0_addr_i     (p0_addr),
    .p0_wr_en_i    (p0_wr_en),
    .p0_rd_en_i    (p0_rd_en),
    .p0_wr_data_i  (p0_wr_data),
    .p0_gnt_o      (p0_gnt),
    .p0_resp_o     (p0_resp),
    .p0_rd_data_o  (p0_rd_data),
    .p1_req_i      (p1_req),
    .p1_addr_i     (p1_addr),
    .p1_wr_en_i    (p1_wr_en),
    .p1_rd_en_i    (p1_rd_en),
    .p1_wr_data_i  (p1_wr_data),
    .p1_gnt_o      (p1_gnt),
    .p1_resp_o     (p1_resp),
    .p1_rd_data_o  (p1_rd_data),
`ifdef DMEM_ARB_LOCK_EN
    .p1_lock_i     (p1_lock),
`endif
    .mem_addr_o    (mem_addr),
    .mem_wr_en_o   (mem_wr_en),
    .mem_rd_en_o   (mem_rd_en),
    .mem_wr_data_o (mem_wr_data),
    .mem_rd_data_i (mem_rd_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: word array with byte-lane writes and combinational read.
  logic [31:0] mem [0:63];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
  end
  assign mem_rd_data = mem[mem_addr[7:2]];
  always @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wr_en[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
    end
  end

  typedef struct {
    logic        req0;
    logic [31:0] addr0;
    logic [3:0]  we0;
    logic [1:0]  rd0;
    logic [31:0] wd0;
    logic        req1;
    logic [31:0] addr1;
    logic [3:0]  we1;
    logic [1:0]  rd1;
    logic [31:0] wd1;
    logic        g0, g1;
    logic [3:0]  mwe;
    logic [1:0]  mrd;
    logic [31:0] maddr;
    logic        r0;
    logic [31:0] d0;
    logic        r1;
    logic [31:0] d1;
  } vec_t;

  localparam int NV = 23;
  vec_t v [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic [3:0] w0,
                       input logic [1:0] d0, input logic [31:0] wd0, input logic r1,
                       input logic [31:0] a1, input logic [3:0] w1, input logic [1:0] d1,
                       input logic [31:0] wd1);
    p0_req = r0; p0_addr = a0; p0_wr_en = w0; p0_rd_en = d0; p0_wr_data = wd0;
    p1_req = r1; p1_addr = a1; p1_wr_en = w1; p1_rd_en = d1; p1_wr_data = wd1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 4'h0, 2'b00, 32'h0, 1'b0, 32'h0, 4'h0, 2'b00, 32'h0);
  endtask

  initial begin
    // Both ports reading continuously from reset: p0 word 0x00, p1 word 0x04.
    v[0]  = '{1,32'h00,0,3,0, 1,32'h04,0,3,0, 1,0, 0,0,32'h00, 0,32'h0,        0,32'h0};
    v[1]  = '{1,32'h00,0,3,0, 1,32'h04,0,3,0, 0,1, 0,3,32'h00, 0,32'h0,        0,32'h0};
    v[2]  = '{1,32'h00,0,3,0, 1,32'h04,0,3,0, 1,0, 0,3,32'h04, 1,32'h10000000, 0,32'h0};
    v[3]  = '{1,32'h00,0,3,0, 1,32'h04,0,3,0, 0,1, 0,3,32'h00, 0,32'h10000000, 1,32'h10000001};
    v[4]  = '{1,32'h00,0,3,0, 1,32'h04,0,3,0, 1,0, 0,3,32'h04, 1,32'h10000000, 0,32'h10000001};
    v[5]  = '{1,32'h00,0,3,0, 1,32'h04,0,3,0, 0,1, 0,3,32'h00, 0,32'h10000000, 1,32'h10000001};
    v[6]  = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,3,32'h04, 1,32'h10000000, 0,32'h10000001};
    v[7]  = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,0,32'h04, 0,32'h10000000, 1,32'h10000001};
    v[8]  = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,0,32'h04, 0,32'h10000000, 0,32'h10000001};
    // Port 1 no-op request: accepted, no enables, resp with zero data.
    v[9]  = '{0,32'h00,0,0,0, 1,32'h30,0,0,0, 0,1, 0,0,32'h04, 0,32'h10000000, 0,32'h10000001};
    v[10] = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,0,32'h30, 0,32'h10000000, 0,32'h10000001};
    v[11] = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,0,32'h30, 0,32'h10000000, 1,32'h0};
    v[12] = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,0,32'h30, 0,32'h10000000, 0,32'h0};
    // Port 0 word write 0xDEADBEEF to 0x10, then word read back.
    v[13] = '{1,32'h10,4'hF,0,32'hDEADBEEF, 0,0,0,0,0, 1,0, 0,0,32'h30, 0,32'h10000000, 0,0};
    v[14] = '{1,32'h10,0,3,0, 0,32'h00,0,0,0, 1,0, 4'hF,0,32'h10, 0,32'h10000000, 0,32'h0};
    v[15] = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,3,32'h10, 1,32'h0,        0,32'h0};
    v[16] = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,0,32'h10, 1,32'hDEADBEEF, 0,32'h0};
    v[17] = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,0,32'h10, 0,32'hDEADBEEF, 0,32'h0};
    // Port 1 byte write 0xAB to 0x21, port 0 half read of 0x20 next cycle.
    v[18] = '{0,32'h00,0,0,0, 1,32'h21,4'h2,0,32'h0000AB00, 0,1, 0,0,32'h10, 0,32'hDEADBEEF, 0,0};
    v[19] = '{1,32'h20,0,2,0, 0,32'h00,0,0,0, 1,0, 4'h2,0,32'h21, 0,32'hDEADBEEF, 0,32'h0};
    v[20] = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,2,32'h20, 0,32'hDEADBEEF, 1,32'h0};
    v[21] = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,0,32'h20, 1,32'h1000AB08, 0,32'h0};
    v[22] = '{0,32'h00,0,0,0, 0,32'h00,0,0,0, 0,0, 0,0,32'h20, 0,32'h1000AB08, 0,32'h0};

    reset = 1'b1;
    idle();
`ifdef DMEM_ARB_LOCK_EN
    p1_lock = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    // Grants must stay low while reset is asserted.
    drive(1'b1, 32'h0, 4'h0, 2'b00, 32'h0, 1'b1, 32'h0, 4'h0, 2'b00, 32'h0);
    #3;
    chk("rst_gnt0", {31'b0, p0_gnt}, 32'd0);
    chk("rst_gnt1", {31'b0, p1_gnt}, 32'd0);
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(v[i].req0, v[i].addr0, v[i].we0, v[i].rd0, v[i].wd0,
            v[i].req1, v[i].addr1, v[i].we1, v[i].rd1, v[i].wd1);
      #3;
      chk($sformatf("v%0d gnt0", i), {31'b0, p0_gnt}, {31'b0, v[i].g0});
      chk($sformatf("v%0d gnt1", i), {31'b0, p1_gnt}, {31'b0, v[i].g1});
      chk($sformatf("v%0d mem_wr_en", i), {28'b0, mem_wr_en}, {28'b0, v[i].mwe});
      chk($sformatf("v%0d mem_rd_en", i), {30'b0, mem_rd_en}, {30'b0, v[i].mrd});
      chk($sformatf("v%0d mem_addr", i), mem_addr, v[i].maddr);
      chk($sformatf("v%0d resp0", i), {31'b0, p0_resp}, {31'b0, v[i].r0});
      chk($sformatf("v%0d resp1", i), {31'b0, p1_resp}, {31'b0, v[i].r1});
      chk($sformatf("v%0d rd_data0", i), p0_rd_data, v[i].d0);
      chk($sformatf("v%0d rd_data1", i), p1_rd_data, v[i].d1);
      if (v[i].mwe != 4'h0) begin
        chk($sformatf("v%0d mem_wr_data", i), mem_wr_data,
            (v[i].mwe == 4'hF) ? 32'hDEADBEEF : 32'h0000AB00);
      end
      next_cycle();
    end

    // Reset one cycle after a port 0 read accept: response dropped, pointer back to port 1.
    drive(1'b1, 32'h0, 4'h0, 2'b11, 32'h0, 1'b0, 32'h0, 4'h0, 2'b00, 32'h0);
    #3;
    chk("rr_accept gnt0", {31'b0, p0_gnt}, 32'd1);
    next_cycle();
    reset = 1'b1;
    drive(1'b1, 32'h0, 4'h0, 2'b00, 32'h0, 1'b1, 32'h0, 4'h0, 2'b00, 32'h0);
    #3;
    chk("rr_in_reset gnt0", {31'b0, p0_gnt}, 32'd0);
    chk("rr_in_reset gnt1", {31'b0, p1_gnt}, 32'd0);
    next_cycle();
    reset = 1'b0;
    #3;
    chk("rr_post mem_rd_en", {30'b0, mem_rd_en}, 32'd0);
    chk("rr_post mem_wr_en", {28'b0, mem_wr_en}, 32'd0);
    chk("rr_post mem_addr", mem_addr, 32'd0);
    chk("rr_post mem_wr_data", mem_wr_data, 32'd0);
    chk("rr_post resp0", {31'b0, p0_resp}, 32'd0);
    chk("rr_post resp1", {31'b0, p1_resp}, 32'd0);
    chk("rr_post rd_data0", p0_rd_data, 32'd0);
    chk("rr_post rd_data1", p1_rd_data, 32'd0);
    chk("rr_post tie gnt0", {31'b0, p0_gnt}, 32'd1);
    chk("rr_post tie gnt1", {31'b0, p1_gnt}, 32'd0);
    next_cycle();
    idle();
    #3;
    chk("rr_post2 resp0", {31'b0, p0_resp}, 32'd0);
    next_cycle();
    #3;
    chk("rr_post3 resp0", {31'b0, p0_resp}, 32'd1);
    chk("rr_post3 rd_data0", p0_rd_data, 32'd0);
    next_cycle();

`ifdef DMEM_ARB_LOCK_EN
    // Pointer is at port 0, so the first tie goes to port 1 and takes the lock.
    p1_lock = 1'b1;
    drive(1'b1, 32'h0, 4'h0, 2'b00, 32'h0, 1'b1, 32'h0, 4'h0, 2'b00, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #3;
      chk($sformatf("lock%0d gnt0", i), {31'b0, p0_gnt}, 32'd0);
      chk($sformatf("lock%0d gnt1", i), {31'b0, p1_gnt}, 32'd1);
      next_cycle();
    end
    p1_req = 1'b0;
    #3;
    chk("lock_idle gnt0", {31'b0, p0_gnt}, 32'd0);
    chk("lock_idle gnt1", {31'b0, p1_gnt}, 32'd0);
    next_cycle();
    p1_lock = 1'b0;
    p1_req  = 1'b1;
    #3;
    chk("unlock gnt0", {31'b0, p0_gnt}, 32'd1);
    chk("unlock gnt1", {31'b0, p1_gnt}, 32'd0);
    next_cycle();
    idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
